// File: rtl/gnt_pkg.sv
// Shared types and grant-vector helpers for the grant arbiter and its packet mux.
package gnt_pkg;

   typedef enum logic {IDLE, LOCK} state_t;

   localparam int MAX_REQS = 32;

   function automatic int popcount(input logic [MAX_REQS-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < MAX_REQS; i++) begin
         n += int'(v[i]);
      end
      return n;
   endfunction

   function automatic logic is_onehot(input logic [MAX_REQS-1:0] v);
      return popcount(v) == 1;
   endfunction

   // OR of set-bit indices; only meaningful when v is one-hot.
   function automatic int onehot_idx(input logic [MAX_REQS-1:0] v);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_REQS; i++) begin
         if (v[i]) begin
            idx |= i;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/gnt_pkt_mux_out_pipe_reg.sv
// Single-entry valid/ready output register carrying one data beat plus its last flag.
module out_pipe_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   input  logic              ready,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              last
);

   // A load wins over a drain so that drain+load in one cycle keeps the slot full.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
         data  <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         last  <= load_last;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/gnt_pkt_mux.sv
// Locks onto the granted requester and forwards its whole packet through a
// registered valid/ready stage, releasing the lock after the last beat is accepted.
module gnt_pkt_mux
   import gnt_pkg::*;
#(
   parameter  int REQS   = 4,
   parameter  int DATA_W = 8,
   parameter  int CNT_W  = 16,
   localparam int IDX_W  = $clog2(REQS)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [REQS-1:0]        gnt_i,
   input  logic [REQS-1:0]        src_valid_i,
   input  logic [REQS*DATA_W-1:0] src_data_i,
   input  logic [REQS-1:0]        src_last_i,
   output logic [REQS-1:0]        src_ready_o,
   output logic                   out_valid_o,
   output logic [DATA_W-1:0]      out_data_o,
   output logic                   out_last_o,
   input  logic                   out_ready_i,
   output logic                   busy_o,
   output logic [IDX_W-1:0]       owner_o,
   output logic                   release_o,
   output logic                   gnt_err_o,
   output logic [CNT_W-1:0]       pkt_cnt_o
);

   state_t            state;
   logic              slot_free;
   logic              owner_valid;
   logic              owner_last;
   logic [DATA_W-1:0] owner_data;
   logic              accept;
   logic [MAX_REQS-1:0] gnt_wide;

   assign gnt_wide    = MAX_REQS'(gnt_i);
   assign slot_free   = !out_valid_o || out_ready_i;
   assign owner_valid = src_valid_i[owner_o];
   assign owner_last  = src_last_i[owner_o];
   assign owner_data  = src_data_i[int'(owner_o)*DATA_W +: DATA_W];
   assign accept      = (state == LOCK) && owner_valid && slot_free;
   assign release_o   = accept && owner_last;

   always_comb begin
      src_ready_o = '0;
      if (state == LOCK) begin
         src_ready_o[owner_o] = slot_free;
      end
   end

   // The grant is only looked at while idle; once locked, only end of packet releases.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         busy_o    <= 1'b0;
         owner_o   <= '0;
         gnt_err_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (is_onehot(gnt_wide)) begin
                  owner_o <= IDX_W'(onehot_idx(gnt_wide));
                  busy_o  <= 1'b1;
                  state   <= LOCK;
               end else if (popcount(gnt_wide) > 1) begin
                  gnt_err_o <= 1'b1;
               end
            end
            LOCK: begin
               if (release_o) begin
                  busy_o <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Packets count as delivered only when their last beat leaves the output stage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pkt_cnt_o <= '0;
      end else if (out_valid_o && out_ready_i && out_last_o) begin
         pkt_cnt_o <= pkt_cnt_o + CNT_W'(1);
      end
   end

   out_pipe_reg #(
      .DATA_W (DATA_W)
   ) u_out_pipe_reg (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (accept),
      .load_data (owner_data),
      .load_last (owner_last),
      .ready     (out_ready_i),
      .valid     (out_valid_o),
      .data      (out_data_o),
      .last      (out_last_o)
   );

endmodule

// File: tb/tb_gnt_pkt_mux.sv
// Self-checking bench for gnt_pkt_mux: directed vector table, hand-written
// reset/wrap sequences, and randomized traffic against a packet-stream model.
module tb_gnt_pkt_mux;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  gnt;
   logic [3:0]  srcValid;
   logic [31:0] srcData;
   logic [3:0]  srcLast;
   logic        outReady;

   logic [3:0]  srcReady;
   logic        outValid;
   logic [7:0]  outData;
   logic        outLast;
   logic        busy;
   logic [1:0]  owner;
   logic        rel;
   logic        gntErr;
   logic [15:0] pktCnt;

   logic [3:0]  wSrcReady;
   logic        wOutValid;
   logic [7:0]  wOutData;
   logic        wOutLast;
   logic        wBusy;
   logic [1:0]  wOwner;
   logic        wRel;
   logic        wGntErr;
   logic [1:0]  wPktCnt;

   int nCmp  = 0;
   int nFail = 0;

   always #5 clk = ~clk;

   gnt_pkt_mux #(.REQS(4), .DATA_W(8), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .gnt_i(gnt), .src_valid_i(srcValid),
      .src_data_i(srcData), .src_last_i(srcLast), .src_ready_o(srcReady),
      .out_valid_o(outValid), .out_data_o(outData), .out_last_o(outLast),
      .out_ready_i(outReady), .busy_o(busy), .owner_o(owner), .release_o(rel),
      .gnt_err_o(gntErr), .pkt_cnt_o(pktCnt)
   );

   gnt_pkt_mux #(.REQS(4), .DATA_W(8), .CNT_W(2)) dutw (
      .clk(clk), .reset_n(reset_n), .gnt_i(gnt), .src_valid_i(srcValid),
      .src_data_i(srcData), .src_last_i(srcLast), .src_ready_o(wSrcReady),
      .out_valid_o(wOutValid), .out_data_o(wOutData), .out_last_o(wOutLast),
      .out_ready_i(outReady), .busy_o(wBusy), .owner_o(wOwner), .release_o(wRel),
      .gnt_err_o(wGntErr), .pkt_cnt_o(wPktCnt)
   );

   typedef struct {
      logic [3:0]  gnt;
      logic [3:0]  valid;
      logic [31:0] data;
      logic [3:0]  last;
      logic        ordy;
      logic [3:0]  srdy;
      logic        busy;
      logic [1:0]  owner;
      logic        ovalid;
      logic [7:0]  odata;
      logic        olast;
      logic        rel;
      logic        err;
      logic [15:0] cnt;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } beat_t;

   vec_t vecs[21];

   task automatic applyStimulus(input logic [3:0] g, input logic [3:0] v,
                                input logic [31:0] d, input logic [3:0] l,
                                input logic r);
      gnt      = g;
      srcValid = v;
      srcData  = d;
      srcLast  = l;
      outReady = r;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      applyStimulus(4'b0, 4'b0, 32'h0, 4'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
   endtask

   int    wrapExp[5] = '{1, 2, 3, 0, 1};
   bit    mLocked;
   int    mOwner;
   bit    mErr;
   int    delivered;
   beat_t curPkt[$];
   beat_t expQ[$];
   beat_t b;

   initial begin
      // gnt, valid, data, last, ordy | srdy, busy, owner, ovalid, odata, olast, rel, err, cnt
      vecs[0]  = '{4'b0100, 4'b0000, 32'h0000_0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 8'h00, 0, 0, 0, 0};
      vecs[1]  = '{4'b0001, 4'b0101, 32'h00A1_0055, 4'b0000, 1, 4'b0100, 1, 2, 0, 8'h00, 0, 0, 0, 0};
      vecs[2]  = '{4'b0001, 4'b0101, 32'h00A2_0055, 4'b0000, 1, 4'b0100, 1, 2, 1, 8'hA1, 0, 0, 0, 0};
      vecs[3]  = '{4'b0001, 4'b0101, 32'h00A3_0055, 4'b0100, 1, 4'b0100, 1, 2, 1, 8'hA2, 0, 1, 0, 0};
      vecs[4]  = '{4'b0001, 4'b0001, 32'h0000_0055, 4'b0000, 1, 4'b0000, 0, 2, 1, 8'hA3, 1, 0, 0, 0};
      vecs[5]  = '{4'b0000, 4'b0001, 32'h0000_00B1, 4'b0000, 0, 4'b0001, 1, 0, 0, 8'hA3, 1, 0, 0, 1};
      for (int i = 6; i < 10; i++)
         vecs[i] = '{4'b0000, 4'b0001, 32'h0000_00B2, 4'b0001, 0, 4'b0000, 1, 0, 1, 8'hB1, 0, 0, 0, 1};
      vecs[10] = '{4'b0000, 4'b0001, 32'h0000_00B2, 4'b0001, 1, 4'b0001, 1, 0, 1, 8'hB1, 0, 1, 0, 1};
      vecs[11] = '{4'b0011, 4'b0000, 32'h0000_0000, 4'b0000, 1, 4'b0000, 0, 0, 1, 8'hB2, 1, 0, 0, 1};
      vecs[12] = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 8'hB2, 1, 0, 1, 2};
      vecs[13] = '{4'b0001, 4'b0000, 32'h0000_0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 8'hB2, 1, 0, 1, 2};
      vecs[14] = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 1, 4'b0001, 1, 0, 0, 8'hB2, 1, 0, 1, 2};
      vecs[15] = '{4'b0000, 4'b0001, 32'h0000_00C1, 4'b0001, 1, 4'b0001, 1, 0, 0, 8'hB2, 1, 1, 1, 2};
      vecs[16] = '{4'b0010, 4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 0, 0, 1, 8'hC1, 1, 0, 1, 2};
      vecs[17] = '{4'b0000, 4'b0010, 32'h0000_D100, 4'b0010, 0, 4'b0000, 1, 1, 1, 8'hC1, 1, 0, 1, 2};
      vecs[18] = '{4'b0000, 4'b0010, 32'h0000_D100, 4'b0010, 1, 4'b0010, 1, 1, 1, 8'hC1, 1, 1, 1, 2};
      vecs[19] = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 1, 4'b0000, 0, 1, 1, 8'hD1, 1, 0, 1, 3};
      vecs[20] = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 1, 4'b0000, 0, 1, 0, 8'hD1, 1, 0, 1, 4};

      doReset();
      checkOutput("reset.busy", busy, 0);
      checkOutput("reset.outValid", outValid, 0);
      checkOutput("reset.pktCnt", pktCnt, 0);

      // Directed vector table
      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i].gnt, vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].ordy);
         checkOutput($sformatf("row%0d.srcReady", i), srcReady, vecs[i].srdy);
         checkOutput($sformatf("row%0d.busy", i), busy, vecs[i].busy);
         checkOutput($sformatf("row%0d.owner", i), owner, vecs[i].owner);
         checkOutput($sformatf("row%0d.outValid", i), outValid, vecs[i].ovalid);
         checkOutput($sformatf("row%0d.outData", i), outData, vecs[i].odata);
         checkOutput($sformatf("row%0d.outLast", i), outLast, vecs[i].olast);
         checkOutput($sformatf("row%0d.release", i), rel, vecs[i].rel);
         checkOutput($sformatf("row%0d.gntErr", i), gntErr, vecs[i].err);
         checkOutput($sformatf("row%0d.pktCnt", i), pktCnt, vecs[i].cnt);
         cycle();
      end

      // Reset between beats 2 and 3 of a packet from source 1
      doReset();
      applyStimulus(4'b0010, 4'b0000, 32'h0, 4'b0000, 1);
      cycle();
      applyStimulus(4'b0000, 4'b0010, 32'h0000_1100, 4'b0000, 1);
      cycle();
      applyStimulus(4'b0000, 4'b0010, 32'h0000_1200, 4'b0000, 1);
      cycle();
      checkOutput("rst.preData", outData, 8'h12);
      checkOutput("rst.preBusy", busy, 1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("rst.busy", busy, 0);
      checkOutput("rst.outValid", outValid, 0);
      checkOutput("rst.outData", outData, 0);
      checkOutput("rst.owner", owner, 0);
      checkOutput("rst.srcReady", srcReady, 0);
      checkOutput("rst.release", rel, 0);
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(4'b1000, 4'b0000, 32'h0, 4'b0000, 1);
      cycle();
      checkOutput("rst.newBusy", busy, 1);
      checkOutput("rst.newOwner", owner, 3);
      applyStimulus(4'b0000, 4'b1000, 32'h2100_0000, 4'b0000, 1);
      cycle();
      checkOutput("rst.y1", outData, 8'h21);
      applyStimulus(4'b0000, 4'b1000, 32'h2200_0000, 4'b1000, 1);
      checkOutput("rst.y2Release", rel, 1);
      cycle();
      checkOutput("rst.y2", outData, 8'h22);
      checkOutput("rst.y2Last", outLast, 1);
      applyStimulus(4'b0000, 4'b0000, 32'h0, 4'b0000, 1);
      cycle();
      checkOutput("rst.pktCnt", pktCnt, 1);
      checkOutput("rst.outValidAfter", outValid, 0);

      // Counter wrap on the narrow-counter instance
      doReset();
      for (int p = 0; p < 5; p++) begin
         applyStimulus(4'b0001, 4'b0000, 32'h0, 4'b0000, 1);
         cycle();
         applyStimulus(4'b0000, 4'b0001, 32'(8'h40 + p), 4'b0001, 1);
         cycle();
         checkOutput($sformatf("wrap%0d.data", p), wOutData, 8'h40 + p);
         applyStimulus(4'b0000, 4'b0000, 32'h0, 4'b0000, 1);
         cycle();
         checkOutput($sformatf("wrap%0d.cnt2", p), wPktCnt, wrapExp[p]);
         checkOutput($sformatf("wrap%0d.cnt16", p), pktCnt, p + 1);
      end

      // Randomized traffic against a packet-stream model
      doReset();
      mLocked   = 0;
      mOwner    = 0;
      mErr      = 0;
      delivered = 0;
      curPkt.delete();
      expQ.delete();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         logic [3:0]  g, v, l, ownerMask;
         logic [31:0] d;
         logic        r, acc;
         int          sel, len;
         bit          drain;
         drain = (cyc >= 1950);
         g = 4'b0;
         if (!mLocked) begin
            sel = $urandom_range(0, 9);
            if (!drain && sel < 5) g = 4'b1 << $urandom_range(0, 3);
            else if (!drain && sel == 5) begin
               int a;
               a = $urandom_range(0, 3);
               g = (4'b1 << a) | (4'b1 << ((a + 1 + $urandom_range(0, 2)) % 4));
            end
         end else begin
            g = 4'($urandom);
         end
         v = 4'($urandom);
         d = $urandom;
         l = 4'($urandom);
         if (mLocked) begin
            v[mOwner] = ($urandom_range(0, 9) < 7);
            d[mOwner*8 +: 8] = curPkt[0].data;
            l[mOwner] = curPkt[0].last;
         end
         r = drain ? 1'b1 : ($urandom_range(0, 9) < 7);
         applyStimulus(g, v, d, l, r);

         ownerMask = mLocked ? (4'b1 << mOwner) : 4'b0;
         checkOutput("rnd.readyOnlyOwner", srcReady & ~ownerMask, 4'b0);
         checkOutput("rnd.busy", busy, mLocked);
         if (mLocked) checkOutput("rnd.owner", owner, mOwner);
         acc = mLocked && v[mOwner] && srcReady[mOwner];
         checkOutput("rnd.release", rel, acc && curPkt[0].last);
         checkOutput("rnd.gntErr", gntErr, mErr);
         checkOutput("rnd.pktCnt", pktCnt, 16'(delivered));
         if (outValid && outReady) begin
            if (expQ.size() == 0) begin
               checkOutput("rnd.spuriousBeat", 1, 0);
            end else begin
               b = expQ.pop_front();
               checkOutput("rnd.outData", outData, b.data);
               checkOutput("rnd.outLast", outLast, b.last);
               if (b.last) delivered++;
            end
         end

         if (mLocked) begin
            if (acc) begin
               b = curPkt.pop_front();
               expQ.push_back(b);
               if (b.last) mLocked = 0;
            end
         end else if ($onehot(g)) begin
            mLocked = 1;
            for (int k = 0; k < 4; k++) if (g[k]) mOwner = k;
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) curPkt.push_back('{8'($urandom), k == len - 1});
         end else if ($countones(g) >= 2) begin
            mErr = 1;
         end
         cycle();
      end
      checkOutput("rnd.endLocked", mLocked, 0);
      checkOutput("rnd.endQueue", expQ.size(), 0);
      checkOutput("rnd.endOutValid", outValid, 0);
      checkOutput("rnd.endPktCnt", pktCnt, 16'(delivered));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule

// File: doc/gnt_pkt_mux.md
Name: gnt_pkt_mux

Overview:
- Downstream consumer of the REQS-way one-hot grant arbiter.
- Takes the arbiter's grant vector and locks onto the granted requester. Forwards that requester's multi-beat packet through a registered valid/ready output stage, then releases the lock at end of packet.
- Each packet leaves as one contiguous stream; beats from different sources never interleave.

Parameters:
- REQS, 4, number of requesters; must equal arbiter REQS; ≥2.
- DATA_W, 8, data beat width in bits.
- CNT_W, 16, width of completed-packet counter.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- gnt_i  in  REQS  grant vector from arbiter; expected one-hot or zero.
- src_valid_i  in  REQS  per-source beat valid.
- src_data_i  in  REQS*DATA_W  per-source data; source k occupies bits [k*DATA_W +: DATA_W].
- src_last_i  in  REQS  per-source end-of-packet marker.
- src_ready_o  out  REQS  per-source ready; at most one bit high.
- out_valid_o  out  1  registered output beat valid.
- out_data_o  out  DATA_W  registered output data.
- out_last_o  out  1  registered output last.
- out_ready_i  in  1  downstream ready.
- busy_o  out  1  high while locked to a source.
- owner_o  out  $clog2(REQS)  index of locked source; holds last owner when idle.
- release_o  out  1  one-cycle pulse when the owner's last beat is accepted.
- gnt_err_o  out  1  sticky; set when gnt_i has more than one bit set.
- pkt_cnt_o  out  CNT_W  packets fully delivered on the output side; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE. All outputs are 0: src_ready_o, out_valid_o, out_data_o, out_last_o, busy_o, owner_o, release_o, gnt_err_o, pkt_cnt_o.
- FSM has two states, IDLE and LOCK.
- IDLE:
  - gnt_i exactly one-hot at bit k → owner_o<=k, busy_o<=1, next state LOCK. The first beat can be accepted the cycle after the grant is seen.
  - gnt_i zero → stay IDLE.
  - gnt_i with ≥2 bits set → stay IDLE, gnt_err_o<=1 (sticky until reset), no lock.
- LOCK:
  - gnt_i is ignored; grant changes mid-packet have no effect.
  - src_ready_o[owner] = (!out_valid_o || out_ready_i). All other src_ready_o bits are 0. This is combinational from out_valid_o and out_ready_i.
  - Accept = src_valid_i[owner] && src_ready_o[owner]. On accept, the output register loads data/last from owner and out_valid_o<=1.
  - Accept with src_last_i[owner]=1 → release_o pulses that cycle (combinational from accept), busy_o<=0, next state IDLE.
  - A new grant can be taken the cycle after release; back-to-back packets are separated by exactly 1 idle input cycle.
- Output register:
  - A beat appears on out_* one cycle after accept.
  - When out_valid_o && out_ready_i and no new accept, out_valid_o<=0.
  - Simultaneous drain and accept → register reloads; out_valid_o stays 1, giving a full-throughput single-beat pipeline.
  - out_data_o/out_last_o hold while out_valid_o && !out_ready_i.
- pkt_cnt_o increments on each output handshake with out_last_o=1. It wraps 2^CNT_W-1 → 0.
- Single-beat packet (valid and last on the first beat) → lock lasts one accept; release_o pulses on that accept.
- The last beat may still sit in the output register while a new owner locks. The new owner's ready waits for that slot.
- reset_n asserted mid-packet: the packet is dropped, the output register is cleared, and no release_o pulse is generated.

Decomposition:
- Shared package gnt_pkg holds:
  - state typedef enum {IDLE, LOCK};
  - function onehot_idx (one-hot → index);
  - function is_onehot / popcount check, reusable by the arbiter's bench.
- Natural sub-module: out_pipe_reg. It is the single-entry valid/ready register with data+last payload, instantiated once.

Test Plan:
- Reset, then gnt_i=0100, source 2 sends 3 beats A1,A2,A3 with last on A3, out_ready_i=1 → out_data_o sequence A1,A2,A3 one cycle after each accept. release_o pulses on the A3 accept; pkt_cnt_o=1; owner_o=2.
- During the source 2 packet, gnt_i switches to 0001 → src_ready_o[0] stays 0; output contains only source 2 beats; lock to 0 occurs after release.
- out_ready_i held 0 for 4 cycles with beat B1 registered → out_data_o holds B1; src_ready_o[owner]=0; no beat lost or duplicated when ready returns.
- gnt_i=0011 in IDLE → no lock; busy_o=0; gnt_err_o=1 and stays 1 after gnt_i returns to 0001.
- reset_n pulsed low between beats 2 and 3 of a 4-beat packet → all outputs 0 immediately (asynchronous); next packet from gnt_i=1000 is delivered intact; pkt_cnt_o=1 after it.
- CNT_W=2, five single-beat packets → pkt_cnt_o reads 1,2,3,0,1.
